// File: rtl/ifu_req_tracker.sv
// rtl/ifu_req_tracker.sv - outstanding fetch tracker with PC FIFO and stale-response masking
module ifu_req_tracker #(
   parameter  int MAX_OUTSTANDING = 4,
   parameter  int PC_W            = 32,
   parameter  int DROP_CNT_W      = 16,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pc_req_vld,
   input  logic                  pc_req_rdy_i,
   output logic                  pc_req_rdy_o,
   input  logic [PC_W-1:0]       pc_req_pc,
   input  logic                  pc_rsp_vld_i,
   output logic                  pc_rsp_rdy_i,
   output logic                  pc_rsp_vld_o,
   input  logic                  pc_rsp_rdy_o,
   output logic [PC_W-1:0]       pc_rsp_pc,
   input  logic                  bpu_redirect,
   input  logic                  exu_flush,
   output logic [CNT_W-1:0]      outstanding,
   output logic                  flush_busy,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output logic                  proto_err
);

   // A single-entry FIFO still needs a one-bit pointer that simply stays at zero.
   localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [CNT_W-1:0]      out_q, out_d;
   logic [CNT_W-1:0]      abandon_q, abandon_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;
   logic                  proto_q, proto_d;
   logic [PC_W-1:0]       pc_mem_q [MAX_OUTSTANDING];

   logic empty;
   logic stale;
   logic req_hs;
   logic rsp_hs;
   logic dlv_hs;
   logic pop;

   // Pointers wrap at the FIFO depth, which need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      next_ptr = (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   assign empty  = (out_q == '0);
   // Abandoned entries are always the oldest, so the head response is stale
   // whenever anything is still abandoned; an empty tracker has no owner for it.
   assign stale  = (abandon_q != '0) | empty;

   // Throttle on the registered count only, keeping response timing off this path.
   assign pc_req_rdy_o = pc_req_rdy_i & (out_q < MAX_CNT);
   assign pc_rsp_rdy_i = stale | pc_rsp_rdy_o;
   assign pc_rsp_vld_o = ~stale & pc_rsp_vld_i;
   assign pc_rsp_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];

   assign req_hs = pc_req_vld & pc_req_rdy_o;
   assign rsp_hs = pc_rsp_vld_i & pc_rsp_rdy_i;
   assign dlv_hs = pc_rsp_vld_o & pc_rsp_rdy_o;
   assign pop    = rsp_hs & ~empty;

   assign outstanding = out_q;
   assign flush_busy  = (abandon_q != '0);
   assign drop_cnt    = drop_q;
   assign proto_err   = proto_q;

   // Occupancy and FIFO pointer next state; a push and pop together cancel out.
   always_comb begin
      out_d    = out_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (req_hs && !pop) begin
         out_d = out_q + CNT_ONE;
      end else if (!req_hs && pop) begin
         out_d = out_q - CNT_ONE;
      end
      if (req_hs) begin
         wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
   end

   // Abandon count: a flush condemns everything still in flight after this
   // cycle's pop, a taken redirect condemns everything behind the delivered
   // response, and otherwise each sunk response retires one abandoned entry.
   // Requests accepted in the same cycle belong to the new path and are excluded.
   always_comb begin
      abandon_d = abandon_q;
      if (exu_flush) begin
         abandon_d = pop ? (out_q - CNT_ONE) : out_q;
      end else if (bpu_redirect && dlv_hs) begin
         abandon_d = out_q - CNT_ONE;
      end else if (rsp_hs && (abandon_q != '0)) begin
         abandon_d = abandon_q - CNT_ONE;
      end
   end

   // Saturating drop statistics and the sticky protocol error flag.
   always_comb begin
      drop_d  = drop_q;
      proto_d = proto_q | (pc_rsp_vld_i & empty);
      if (rsp_hs && stale && (drop_q != '1)) begin
         drop_d = drop_q + DROP_CNT_W'(1);
      end
   end

   // Control state, discarded immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q     <= '0;
         abandon_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         drop_q    <= '0;
         proto_q   <= 1'b0;
      end else begin
         out_q     <= out_d;
         abandon_q <= abandon_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         drop_q    <= drop_d;
         proto_q   <= proto_d;
      end
   end

   // PC storage needs no reset: entries are only read while the count covers them.
   always_ff @(posedge clk) begin
      if (req_hs) begin
         pc_mem_q[wr_ptr_q] <= pc_req_pc;
      end
   end

endmodule
